// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: accepts a binary value over valid/ready, converts it to
// packed BCD with a one-iteration-per-cycle double-dabble engine, and scans the
// digits onto a shared 4-bit BCD bus with a one-hot digit enable.
// Optional feature: define BCD_SCAN_BLANK_EN for leading-zero blanking (code 4'hF).
module bcd_display_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic [3:0]        bcd_out,
  output logic [DIGITS-1:0] digit_en,
  output logic              overflow
);

  localparam int unsigned AccW  = 4 * DIGITS;
  localparam int unsigned IterW = $clog2(BIN_W + 1);
  localparam int unsigned PresW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CmpW  = (BIN_W > 32) ? BIN_W : 32;
  localparam logic [CmpW-1:0] MaxVal = CmpW'(10 ** DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_nxt;
  logic [AccW-1:0]     acc_q, acc_adj, acc_nxt;
  logic [IterW-1:0]    iter_q;
  logic                ovf_next_q;
  logic [AccW-1:0]     disp_q;
  logic                overflow_q;
  logic [PresW-1:0]    presc_q;
  logic [IdxW-1:0]     idx_q;
  logic                accept, last_iter, presc_wrap;
  logic [DIGITS-1:0]   blank;

  assign accept     = (state_q == StIdle) && bin_valid;
  assign last_iter  = (state_q == StConvert) && (iter_q == IterW'(BIN_W - 1));
  assign presc_wrap = (presc_q == PresW'(SCAN_DIV - 1));
  assign overflow   = overflow_q;

  // One double-dabble iteration: add-3 on nibbles >= 5, then shift left by one.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    // The top accumulator bit falls off; only overflowing values lose it and
    // those are saturated anyway.
    {acc_nxt, shift_nxt} = {acc_adj[AccW-2:0], shift_q, 1'b0};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state: stay in CONVERT for exactly BIN_W cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bin_valid) state_d = StConvert;
      StConvert: if (last_iter) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bin_ready = (state_q == StIdle);
  end

  // Conversion datapath and display register; display changes only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      acc_q      <= '0;
      iter_q     <= '0;
      ovf_next_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      shift_q    <= bin_in;
      acc_q      <= '0;
      iter_q     <= '0;
      ovf_next_q <= CmpW'(bin_in) > MaxVal;
    end else if (state_q == StConvert) begin
      shift_q <= shift_nxt;
      acc_q   <= acc_nxt;
      iter_q  <= iter_q + 1'b1;
      if (last_iter) begin
        disp_q     <= ovf_next_q ? {DIGITS{4'h9}} : acc_nxt;
        overflow_q <= ovf_next_q;
      end
    end
  end

  // Free-running scan: prescaler wraps every SCAN_DIV cycles and advances the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_wrap) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

`ifdef BCD_SCAN_BLANK_EN
  // Blank every digit above the most significant non-zero one; digit 0 always shows.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      seen     = seen | (disp_q[4*i +: 4] != 4'd0);
      blank[i] = ~seen;
    end
  end
`else
  assign blank = '0;
`endif

  // Digit mux and one-hot enable from the registered scan index.
  always_comb begin
    bcd_out  = 4'd0;
    digit_en = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        digit_en[i] = 1'b1;
        bcd_out     = blank[i] ? 4'hF : disp_q[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed scenarios plus random
// values, checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_display_scanner;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BIN_W    = 14;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned MaxDisp  = 9999;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              bin_valid = 1'b0;
  logic              bin_ready;
  logic [3:0]        bcd_out;
  logic [DIGITS-1:0] digit_en;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  bcd_display_scanner #(
    .DIGITS  (DIGITS),
    .BIN_W   (BIN_W),
    .SCAN_DIV(SCAN_DIV)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bin_in   (bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .bcd_out  (bcd_out),
    .digit_en (digit_en),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp,
               $time);
    end
  endtask

  // Reference model: a value taken in at a handshake appears, saturated, BIN_W edges later.
  int m_cyc, m_left, m_pend, m_disp;
  bit m_busy, m_ovf;
  int acc_cyc, prev_acc_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_busy <= 1'b0;
      m_left <= 0;
      m_pend <= 0;
      m_disp <= 0;
      m_ovf  <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_disp <= (m_pend > int'(MaxDisp)) ? int'(MaxDisp) : m_pend;
          m_ovf  <= (m_pend > int'(MaxDisp));
        end
      end else if (bin_valid) begin
        m_busy <= 1'b1;
        m_left <= BIN_W;
        m_pend <= int'(bin_in);
      end
    end
  end

  // Timestamp of accepted handshakes, taken with a free-running cycle counter.
  int tb_cyc = 0;
  always @(posedge clk) begin
    tb_cyc <= tb_cyc + 1;
    if (rst_n && bin_valid && bin_ready) begin
      prev_acc_cyc <= acc_cyc;
      acc_cyc      <= tb_cyc;
    end
  end

  function automatic int exp_digit(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
`ifdef BCD_SCAN_BLANK_EN
    if (i > 0 && v < p) return 15;
`endif
    return (v / p) % 10;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int idx;
    idx = (m_cyc / int'(SCAN_DIV)) % int'(DIGITS);
    check("bin_ready", int'(bin_ready), int'(!m_busy));
    check("overflow", int'(overflow), int'(m_ovf));
    check("digit_en", int'(digit_en), 1 << idx);
    check("bcd_out", int'(bcd_out), exp_digit(m_disp, idx));
  end

  task automatic send(input int v);
    int n;
    @(negedge clk);
    bin_in    = BIN_W'(v);
    bin_valid = 1'b1;
    n = 0;
    while (!bin_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", int'(bin_ready), 1);
    @(negedge clk);
    bin_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bin_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(bin_ready), 1);
  endtask

  // Walk one full scan round and compare each enabled digit with a fixed table.
  task automatic scan_check(input string tag, input int e0, input int e1, input int e2,
                            input int e3);
    int exp_tab[4];
    exp_tab = '{e0, e1, e2, e3};
    for (int c = 0; c < int'(DIGITS * SCAN_DIV); c++) begin
      @(negedge clk);
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (digit_en[i]) check(tag, int'(bcd_out), exp_tab[i]);
      end
    end
  endtask

  initial begin
    int low_cnt, blank_hi, v;

    // Reset state.
    #12;
    check("rst_ready", int'(bin_ready), 1);
    check("rst_digit_en", int'(digit_en), 1);
    check("rst_bcd", int'(bcd_out), 0);
    check("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1234: ready low for exactly BIN_W cycles, then digits 4,3,2,1.
    send(1234);
    low_cnt = 1;
    while (!bin_ready && low_cnt < 60) begin
      @(negedge clk);
      if (!bin_ready) low_cnt++;
    end
    check("ready_low_cycles", low_cnt, int'(BIN_W));
    scan_check("scan_1234", 4, 3, 2, 1);
    check("ovf_1234", int'(overflow), 0);

    // Saturation and its clearing.
    send(12000);
    wait_idle();
    check("ovf_12000", int'(overflow), 1);
    scan_check("scan_12000", 9, 9, 9, 9);
    send(5);
    wait_idle();
    check("ovf_cleared", int'(overflow), 0);

    // Held valid: 42 is converted; 7 presented during CONVERT waits for ready.
    @(negedge clk);
    bin_in    = BIN_W'(42);
    bin_valid = 1'b1;
    @(negedge clk);
    bin_in = BIN_W'(7);
    wait_idle();
    @(negedge clk);
    bin_valid = 1'b0;
    check("hs_gap", acc_cyc - prev_acc_cyc, int'(BIN_W) + 1);
    check("hs_ready_low", int'(bin_ready), 0);
    wait_idle();
    blank_hi = 0;
`ifdef BCD_SCAN_BLANK_EN
    blank_hi = 15;
`endif
    scan_check("scan_7", 7, blank_hi, blank_hi, blank_hi);

    // Zero shows a single 0 when blanking.
    send(0);
    wait_idle();
    scan_check("scan_0", 0, blank_hi, blank_hi, blank_hi);

    // Reset at iteration 6 of 9999 discards everything.
    send(9999);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", int'(bin_ready), 1);
    check("midrst_digit_en", int'(digit_en), 1);
    check("midrst_bcd", int'(bcd_out), 0);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_ovf", int'(overflow), 0);

    // Random values with random idle gaps.
    for (int t = 0; t < 40; t++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                      : int'($urandom_range(0, 9999));
      send(v);
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
